// File: rtl/gif_frame_scheduler.sv
// gif_frame_scheduler: picks the frame shown on the 64x32 HUB75 panel.
// Handles dwell timing, play/pause/single-step and the per-frame duration.
// Frame changes wait for the panel's refresh-boundary pulse so the memory
// frame select never moves in the middle of a scan.
module gif_frame_scheduler #(
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_W     = 2,
  parameter int DUR_W       = 24,
  parameter int DEFAULT_DUR = 12500000,
  parameter bit AUTOPLAY    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  input  logic [DUR_W-1:0]   cmd_data,
  output logic               cmd_ready,
  input  logic               scan_done,
  output logic [FRAME_W-1:0] frame_sel,
  output logic               frame_changed,
  output logic               loop_done,
  output logic               playing
);

  typedef enum logic [1:0] {
    ST_PAUSED    = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_WAIT_SCAN = 2'd2
  } state_t;

  localparam logic [1:0] OP_PLAY    = 2'd0;
  localparam logic [1:0] OP_PAUSE   = 2'd1;
  localparam logic [1:0] OP_STEP    = 2'd2;
  localparam logic [1:0] OP_SET_DUR = 2'd3;

  localparam state_t             RESET_STATE = AUTOPLAY ? ST_PLAYING : ST_PAUSED;
  localparam logic [FRAME_W-1:0] LAST_FRAME  = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [DUR_W-1:0]   RESET_DUR   = DUR_W'(DEFAULT_DUR);

  state_t             state_reg;
  state_t             ret_reg;
  logic [DUR_W-1:0]   cnt_reg;
  logic [DUR_W-1:0]   dur_reg;
  logic [FRAME_W-1:0] frame_sel_reg;
  logic               frame_changed_reg;
  logic               loop_done_reg;

  logic               cmd_accept;
  logic               dwell_expired;
  logic [DUR_W-1:0]   dur_next;
  logic [FRAME_W-1:0] frame_next;
  logic               frame_wrap;

  // Commands are only taken outside WAIT_SCAN; nothing is ever queued.
  assign cmd_accept    = cmd_valid && (state_reg != ST_WAIT_SCAN);
  // dur_reg is never 0, so dur_reg-1 cannot underflow. The >= compare makes a
  // shrink below the running count expire right away instead of wrapping.
  assign dwell_expired = (cnt_reg >= (dur_reg - DUR_W'(1)));
  // A zero duration would never expire cleanly, so it is clamped to 1.
  assign dur_next      = (cmd_data == '0) ? DUR_W'(1) : cmd_data;
  assign frame_wrap    = (frame_sel_reg == LAST_FRAME);
  assign frame_next    = frame_wrap ? '0 : (frame_sel_reg + FRAME_W'(1));

  assign cmd_ready     = (state_reg != ST_WAIT_SCAN);
  assign playing       = (state_reg == ST_PLAYING) ||
                         ((state_reg == ST_WAIT_SCAN) && (ret_reg == ST_PLAYING));
  assign frame_sel     = frame_sel_reg;
  assign frame_changed = frame_changed_reg;
  assign loop_done     = loop_done_reg;

  // Playback FSM with dwell counter, duration register and registered frame outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= RESET_STATE;
      ret_reg           <= RESET_STATE;
      cnt_reg           <= '0;
      dur_reg           <= RESET_DUR;
      frame_sel_reg     <= '0;
      frame_changed_reg <= 1'b0;
      loop_done_reg     <= 1'b0;
    end else begin
      // Pulses are one cycle wide unless re-asserted below.
      frame_changed_reg <= 1'b0;
      loop_done_reg     <= 1'b0;

      case (state_reg)
        ST_PAUSED: begin
          // Counter is frozen while paused; PAUSE is a no-op here.
          if (cmd_accept) begin
            case (cmd_op)
              OP_PLAY: begin
                state_reg <= ST_PLAYING;
                cnt_reg   <= '0;
              end
              OP_STEP: begin
                state_reg <= ST_WAIT_SCAN;
                ret_reg   <= ST_PAUSED;
              end
              OP_SET_DUR: dur_reg <= dur_next;
              default: ;
            endcase
          end
        end

        ST_PLAYING: begin
          if (cmd_accept && (cmd_op == OP_PAUSE)) begin
            // PAUSE beats a simultaneous expiry: no advance is left pending.
            state_reg <= ST_PAUSED;
          end else if (cmd_accept && (cmd_op == OP_STEP)) begin
            state_reg <= ST_WAIT_SCAN;
            ret_reg   <= ST_PLAYING;
            cnt_reg   <= '0;
          end else begin
            // The counter keeps running across a SET_DUR; the new duration
            // applies from the next compare onward.
            if (cmd_accept && (cmd_op == OP_SET_DUR)) begin
              dur_reg <= dur_next;
            end
            if (dwell_expired) begin
              state_reg <= ST_WAIT_SCAN;
              ret_reg   <= ST_PLAYING;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + DUR_W'(1);
            end
          end
        end

        ST_WAIT_SCAN: begin
          // Only a scan boundary seen while already waiting moves the frame.
          if (scan_done) begin
            frame_sel_reg     <= frame_next;
            frame_changed_reg <= 1'b1;
            loop_done_reg     <= frame_wrap;
            state_reg         <= ret_reg;
            cnt_reg           <= '0;
          end
        end

        default: begin
          state_reg <= RESET_STATE;
          ret_reg   <= RESET_STATE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gif_frame_scheduler.sv
// tb_gif_frame_scheduler: directed and randomized stimulus for the GIF frame
// scheduler, scored against a behavioural playback model. Frame-change events
// are queued by the model and consumed by an independent monitor.
module tb_gif_frame_scheduler;

  localparam int NF  = 4;
  localparam int FW  = 2;
  localparam int DW  = 24;
  localparam int DEF = 50;
  localparam bit AP  = 1'b1;

  localparam int OP_PLAY = 0, OP_PAUSE = 1, OP_STEP = 2, OP_SETDUR = 3;
  localparam int M_PAUSED = 0, M_PLAY = 1, M_WAIT = 2;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready;
  logic          scan_done;
  logic [FW-1:0] frame_sel;
  logic          frame_changed;
  logic          loop_done;
  logic          playing;

  gif_frame_scheduler #(
    .NUM_FRAMES (NF),
    .FRAME_W    (FW),
    .DUR_W      (DW),
    .DEFAULT_DUR(DEF),
    .AUTOPLAY   (AP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .scan_done    (scan_done),
    .frame_sel    (frame_sel),
    .frame_changed(frame_changed),
    .loop_done    (loop_done),
    .playing      (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int n_events = 0;

  typedef struct {
    int cyc;
    int frame;
    bit wrap;
  } ev_t;
  ev_t exp_q[$];

  // Reference playback model: mode, return mode, dwell count, duration, frame.
  int    m_mode, m_ret, m_frame;
  longint m_cnt, m_dur;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    m_mode  = AP ? M_PLAY : M_PAUSED;
    m_ret   = m_mode;
    m_cnt   = 0;
    m_dur   = DEF;
    m_frame = 0;
    exp_q.delete();
  endfunction

  // Outcome of one clock edge given the inputs presented to it.
  function automatic void model_step(bit cv, int op, int data, bit sd);
    bit     acc;
    bit     expired;
    bit     wrap;
    longint nd;
    acc = cv && (m_mode != M_WAIT);
    nd  = (data == 0) ? 1 : data;
    case (m_mode)
      M_PAUSED: begin
        if (acc && op == OP_PLAY) begin
          m_mode = M_PLAY;
          m_cnt  = 0;
        end else if (acc && op == OP_STEP) begin
          m_mode = M_WAIT;
          m_ret  = M_PAUSED;
        end else if (acc && op == OP_SETDUR) begin
          m_dur = nd;
        end
      end
      M_PLAY: begin
        if (acc && op == OP_PAUSE) begin
          m_mode = M_PAUSED;
        end else if (acc && op == OP_STEP) begin
          m_mode = M_WAIT;
          m_ret  = M_PLAY;
          m_cnt  = 0;
        end else begin
          expired = (m_cnt >= m_dur - 1);
          if (acc && op == OP_SETDUR) m_dur = nd;
          if (expired) begin
            m_mode = M_WAIT;
            m_ret  = M_PLAY;
            m_cnt  = 0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
      default: begin
        if (sd) begin
          wrap    = (m_frame == NF - 1);
          m_frame = wrap ? 0 : m_frame + 1;
          exp_q.push_back('{cyc + 1, m_frame, wrap});
          m_mode  = m_ret;
          m_cnt   = 0;
        end
      end
    endcase
  endfunction

  // Present one cycle of inputs, sampled by the next rising edge.
  task automatic cycle(input bit cv, input int op, input int data, input bit sd);
    @(posedge clk);
    #2;
    cmd_valid = cv;
    cmd_op    = op[1:0];
    cmd_data  = data[DW-1:0];
    scan_done = sd;
    if (rst) model_step(cv, op, data, sd);
    else     model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    scan_done = 1'b0;
    model_step(1'b0, 0, 0, 1'b0);
  endtask

  // Drop reset between edges and check the outputs clear without a clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    chk("pre_reset_ready", cmd_ready, (m_mode == M_WAIT) ? 0 : 1);
    chk("pre_reset_frame", frame_sel, m_frame);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    scan_done = 1'b0;
    model_reset();
    #1;
    chk("rst_frame_sel", frame_sel, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_frame_changed", frame_changed, 0);
    chk("rst_loop_done", loop_done, 0);
    chk("rst_playing", playing, AP);
    repeat (3) cycle(1'b0, 0, 0, 1'b0);
    release_reset();
  endtask

  // Issue a command once the model says it will be accepted.
  task automatic issue(input int op, input int data);
    for (int i = 0; i < 300 && m_mode == M_WAIT; i++) cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b1, op, data, 1'b0);
  endtask

  task automatic wait_play_cnt(input longint target);
    for (int i = 0; i < 400; i++) begin
      if (m_mode == M_PLAY && m_cnt == target) return;
      cycle(1'b0, 0, 0, m_mode == M_WAIT);
    end
    errors++;
    checks++;
    $display("FAIL wait_play_cnt: timed out waiting for count %0d", target);
  endtask

  // Monitor: compare DUT outputs with the model each cycle, consume frame events.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("frame_sel", frame_sel, m_frame);
      chk("cmd_ready", cmd_ready, (m_mode == M_WAIT) ? 0 : 1);
      chk("playing", playing,
          (m_mode == M_PLAY || (m_mode == M_WAIT && m_ret == M_PLAY)) ? 1 : 0);
      if (frame_changed) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_changed", frame_changed, 0);
        end else begin
          e = exp_q.pop_front();
          n_events++;
          chk("event_cycle", cyc, e.cyc);
          chk("event_frame", frame_sel, e.frame);
          chk("event_loop_done", loop_done, e.wrap);
          $display("frame change: cycle=%0d frame_sel=%0d loop_done=%0b",
                   cyc, frame_sel, loop_done);
        end
      end else begin
        chk("loop_done_idle", loop_done, 0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          chk("frame_changed_pulse", frame_changed, 1);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    scan_done = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("init_frame_sel", frame_sel, 0);
    chk("init_cmd_ready", cmd_ready, 1);
    chk("init_frame_changed", frame_changed, 0);
    chk("init_loop_done", loop_done, 0);
    chk("init_playing", playing, AP);
    repeat (3) cycle(1'b0, 0, 0, 1'b0);
    release_reset();

    // Dwell 10, scan boundary every 40 cycles: full loop with wrap.
    cycle(1'b1, OP_SETDUR, 10, 1'b0);
    for (int i = 0; i < 200; i++) cycle(1'b0, 0, 0, (i % 40) == 39);

    // Expire, then keep the scan boundary away for 100 cycles.
    for (int i = 0; i < 100 && m_mode != M_WAIT; i++) cycle(1'b0, 0, 0, 1'b0);
    repeat (100) cycle(1'b0, 0, 0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    repeat (3) cycle(1'b0, 0, 0, 1'b0);

    // Pause at count 5, ignore scan pulses, then resume.
    wait_play_cnt(5);
    cycle(1'b1, OP_PAUSE, 0, 1'b0);
    for (int i = 0; i < 50; i++) cycle(1'b0, 0, 0, (i % 10) == 9);
    cycle(1'b1, OP_PLAY, 0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 0, 0, (i % 7) == 6);

    // Single-step through frames while paused, including the wrap.
    issue(OP_PAUSE, 0);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, OP_STEP, 0, 1'b0);
      repeat (2) cycle(1'b0, 0, 0, 1'b0);
      cycle(1'b0, 0, 0, 1'b1);
      repeat (2) cycle(1'b0, 0, 0, 1'b0);
    end

    // Zero duration clamps to 1; then shrink 20 -> 3 at count 8.
    issue(OP_SETDUR, 0);
    issue(OP_PLAY, 0);
    repeat (20) cycle(1'b0, 0, 0, 1'b1);
    issue(OP_SETDUR, 20);
    wait_play_cnt(8);
    cycle(1'b1, OP_SETDUR, 3, 1'b0);
    repeat (4) cycle(1'b0, 0, 0, 1'b0);
    repeat (10) cycle(1'b0, 0, 0, 1'b1);

    // Reach frame 2, step into WAIT_SCAN, then reset asynchronously.
    issue(OP_SETDUR, 4);
    for (int i = 0; i < 300; i++) begin
      if (m_frame == 2 && m_mode == M_PLAY) break;
      cycle(1'b0, 0, 0, $urandom_range(0, 2) == 0);
    end
    cycle(1'b1, OP_STEP, 0, 1'b0);
    repeat (3) cycle(1'b0, 0, 0, 1'b0);
    async_reset();

    // Randomized commands and scan boundaries, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3),
            $urandom_range(0, 12), $urandom_range(0, 5) == 0);
    end

    repeat (5) cycle(1'b0, 0, 0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    checks++;
    if (n_events < 10) begin
      errors++;
      $display("FAIL event_count: got %0d frame changes, required at least 10", n_events);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gif_frame_scheduler.md
# gif_frame_scheduler

Playback scheduler for the 64x32 HUB75 GIF path. Decides which stored frame the panel shows, and when it changes. Frame dwell time, play/pause/single-step and the per-frame duration are all under command control. Frame changes are deferred to panel refresh boundaries, so the multi-frame memory's frame select never switches mid-scan and the image cannot tear. Sits between the user/command source and the frame-select input of the GIF memory; the panel scan controller supplies the refresh-boundary pulse.

## Interface
Parameters:
- NUM_FRAMES, 4: frames stored in memory; legal 2..2^FRAME_W.
- FRAME_W, 2: width of the frame index.
- DUR_W, 24: width of the duration register and dwell counter.
- DEFAULT_DUR, 12500000: dwell time in clk cycles loaded at reset (500 ms at 25 MHz).
- AUTOPLAY, 1: 1 = leave reset in PLAYING; 0 = leave reset in PAUSED.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_op  in  2  0 PLAY, 1 PAUSE, 2 STEP, 3 SET_DUR.
- cmd_data  in  DUR_W  new duration; used by SET_DUR only.
- cmd_ready  out  1  command accepted on any edge where cmd_valid & cmd_ready.
- scan_done  in  1  one-cycle pulse, synchronous to clk: the panel has finished a full 32-row refresh.
- frame_sel  out  FRAME_W  current frame index, drives the memory frame select.
- frame_changed  out  1  one-cycle pulse, high in the same cycle frame_sel takes its new value.
- loop_done  out  1  one-cycle pulse, high with frame_changed when frame_sel wraps to 0.
- playing  out  1  high in PLAYING, or in WAIT_SCAN when the return state is PLAYING.

## Operation
- State registers: state (PAUSED, PLAYING, WAIT_SCAN), ret (return state), dwell counter cnt, duration register dur.
- PAUSED:
  - cnt holds its value.
  - PLAY: go to PLAYING, cnt <= 0.
  - STEP: go to WAIT_SCAN with ret = PAUSED.
  - PAUSE: no effect.
- PLAYING:
  - cnt increments each cycle.
  - When cnt >= dur-1: go to WAIT_SCAN with ret = PLAYING, cnt <= 0.
  - PAUSE: go to PAUSED, cnt holds.
  - STEP: go to WAIT_SCAN immediately with ret = PLAYING, cnt <= 0.
  - PLAY: no effect.
  - If PAUSE and expiry happen in the same cycle, PAUSE wins and no advance is pending.
- WAIT_SCAN:
  - cmd_ready = 0.
  - On scan_done: frame_sel <= (frame_sel == NUM_FRAMES-1) ? 0 : frame_sel+1. frame_changed is pulsed. loop_done is pulsed on wrap. state <= ret, cnt <= 0.
- scan_done in PAUSED or PLAYING is ignored. A scan_done in the same cycle as the PLAYING->WAIT_SCAN transition does not advance the frame; the block waits for the next pulse.
- SET_DUR is accepted in PAUSED and PLAYING. dur <= (cmd_data == 0) ? 1 : cmd_data. The cnt value is kept. Because the compare is >=, shrinking dur below cnt expires on the next cycle.
- cmd_ready = (state != WAIT_SCAN). Commands are never queued. cmd_valid held while ready is low simply waits.
- Reset values:
  - frame_sel = 0, frame_changed = 0, loop_done = 0, cnt = 0, dur = DEFAULT_DUR.
  - state = PLAYING if AUTOPLAY, else PAUSED. playing = AUTOPLAY. cmd_ready = 1.
- Reset asserted mid-operation (any state) returns everything to the reset values asynchronously. No frame_changed pulse is produced.

## Timing
- With dur = D, starting PLAYING at cnt = 0, the block spends exactly D cycles in PLAYING before WAIT_SCAN.
- frame_sel, frame_changed and loop_done update on the clk edge that samples scan_done high in WAIT_SCAN. Latency from scan_done to the new frame_sel is 1 edge.
- After the advance, the next dwell starts in that same edge (cnt = 0). The displayed dwell is therefore D cycles plus the wait for the next scan boundary.
- All outputs are registered, except cmd_ready (decoded from state) and playing (decoded from state/ret).
- A command takes effect on the accepting edge. Its state change is visible the following cycle.

## Test plan
- Reset, AUTOPLAY=1, SET_DUR 10, then scan_done pulse every 40 cycles. Required: frame_sel 0->1->2->3->0, each change aligned to a scan_done; loop_done only on 3->0; frame_changed exactly 1 cycle wide.
- Dur 10, scan_done held off 100 cycles after expiry. Required: frame_sel stays; cmd_ready = 0 throughout; advance on the first scan_done; cmd_ready returns to 1 the next cycle.
- PAUSE at cnt = 5 (dur 10), wait 50 cycles, then PLAY. Required: no advance while paused; PLAYING resumes with cnt = 0, and the advance comes 10 cycles later, at the next scan_done.
- In PAUSED at frame 2, STEP, then scan_done. Required: frame_sel = 3; state returns to PAUSED with playing = 0. A second STEP plus scan_done gives frame_sel = 0 with loop_done = 1.
- SET_DUR 0, then SET_DUR 3 while cnt = 8. Required: dur reads as 1 and WAIT_SCAN follows every cycle of PLAYING; the shrink to 3 expires on the next cycle.
- Assert rst low during WAIT_SCAN at frame 2. Required: frame_sel = 0, cmd_ready = 1, no frame_changed pulse, state per AUTOPLAY.
